// File: rtl/baud_tick_generator.sv
// Fractional-N UART oversampling tick generator.
// Emits a sample tick per divisor period and a bit tick every OVERSAMPLE samples.
module baud_tick_generator #(
  parameter int INT_W        = 11,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INT  = 325,
  parameter int DEFAULT_FRAC = 0,
  localparam int IDX_W       = $clog2(OVERSAMPLE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [INT_W-1:0]  dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic [IDX_W-1:0]  sample_idx,
  output logic              pending
);

  // One extra bit so a fractional stretch of the largest divisor still fits.
  localparam int CNT_W = INT_W + 1;

  localparam logic [INT_W-1:0]  RST_INT  = INT_W'(DEFAULT_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  logic [INT_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic [INT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [CNT_W-1:0]  count;
  logic [FRAC_W-1:0] frac_acc;
  logic              extend;
  logic [IDX_W-1:0]  idx;

  logic [CNT_W-1:0]  terminal;
  logic              at_term;
  logic              step;
  logic [FRAC_W:0]   acc_sum;
  logic              idx_last;

  // Period end: base divisor, stretched by one cycle after a fractional carry.
  assign terminal = {1'b0, act_int} + CNT_W'(extend);
  assign at_term  = (count == terminal);
  assign step     = enable & at_term;
  assign acc_sum  = {1'b0, frac_acc} + {1'b0, act_frac};
  assign idx_last = (idx == IDX_LAST);

  assign sample_idx = idx;

  // Shadow divisor: captured on every load strobe, gated or not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_int  <= RST_INT;
      sh_frac <= RST_FRAC;
    end else if (load) begin
      sh_int  <= dvsr_int;
      sh_frac <= dvsr_frac;
    end
  end

  // Pending flag: set by load, dropped when the shadow goes live.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (step) begin
      pending <= 1'b0;
    end
  end

  // Active divisor: swapped at a period boundary, or at once on clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
    end else if (clear) begin
      act_int  <= load ? dvsr_int : sh_int;
      act_frac <= load ? dvsr_frac : sh_frac;
    end else if (step && pending) begin
      act_int  <= sh_int;
      act_frac <= sh_frac;
    end
  end

  // Period counter: runs 0..terminal while enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (at_term) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Fractional accumulator: its carry stretches the next period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frac_acc <= '0;
      extend   <= 1'b0;
    end else if (clear) begin
      frac_acc <= '0;
      extend   <= 1'b0;
    end else if (step) begin
      {extend, frac_acc} <= acc_sum;
    end
  end

  // Oversample index: wraps naturally since OVERSAMPLE is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Registered tick outputs, forced low while gated or restarting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else if (clear || !enable) begin
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      sample_tick <= at_term;
      bit_tick    <= at_term & idx_last;
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator.
// Expected spacings are hand-computed from the divisor settings.
module tb_baud_tick_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        load;
  logic [10:0] dvsr_int;
  logic [3:0]  dvsr_frac;
  logic        sample_tick;
  logic        bit_tick;
  logic [3:0]  sample_idx;
  logic        pending;

  int n_pass  = 0;
  int n_check = 0;

  always #5 clock = ~clock;

  baud_tick_generator dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .dvsr_int   (dvsr_int),
    .dvsr_frac  (dvsr_frac),
    .sample_tick(sample_tick),
    .bit_tick   (bit_tick),
    .sample_idx (sample_idx),
    .pending    (pending)
  );

  // Steps negedges until sample_tick is seen; -1 if the bound expires.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sample_tick && n < limit);
    if (!sample_tick) n = -1;
  endtask

  // clear+load: new divisor live immediately, everything restarted.
  task automatic restart(input int iv, input int fv);
    clear     = 1'b1;
    load      = 1'b1;
    dvsr_int  = 11'(iv);
    dvsr_frac = 4'(fv);
    @(negedge clock);
    clear = 1'b0;
    load  = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
    dvsr_int = '0; dvsr_frac = '0;
    #3;
    n_check++;
    if ({sample_tick, bit_tick, pending, sample_idx} !== 7'd0)
      $display("FAIL reset_outs got=%b exp=0",
               {sample_tick, bit_tick, pending, sample_idx});
    else n_pass++;
    @(negedge clock);
    reset = 1'b1; enable = 1'b1;
    wait_tick(400, n);
    n_check++;
    if (n !== 326) $display("FAIL reset_latency got=%0d exp=326", n);
    else n_pass++;
  endtask

  task automatic test_bit_tick;
    int n;
    int t;
    int last_bit;
    @(negedge clock);
    restart(3, 0);
    n_check++;
    if ({pending, sample_idx, sample_tick} !== 6'd0)
      $display("FAIL restart_state got=%b exp=0",
               {pending, sample_idx, sample_tick});
    else n_pass++;
    t = 0;
    last_bit = -1;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(20, n);
      t += n;
      n_check++;
      if (n !== 4) $display("FAIL spacing4 k=%0d got=%0d exp=4", k, n);
      else n_pass++;
      n_check++;
      if (sample_idx !== 4'(k % 16))
        $display("FAIL idx k=%0d got=%0d exp=%0d", k, sample_idx, k % 16);
      else n_pass++;
      n_check++;
      if (bit_tick !== (k % 16 == 0))
        $display("FAIL bit_tick k=%0d got=%b exp=%b", k, bit_tick,
                 (k % 16 == 0));
      else n_pass++;
      if (bit_tick) begin
        if (last_bit >= 0) begin
          n_check++;
          if (t - last_bit !== 64)
            $display("FAIL bit_period got=%0d exp=64", t - last_bit);
          else n_pass++;
        end
        last_bit = t;
      end
    end
  endtask

  task automatic test_frac;
    int n;
    int t;
    int exp_sp [5] = '{4, 4, 5, 4, 5};
    restart(3, 8);
    t = 0;
    for (int k = 0; k < 20; k++) begin
      wait_tick(20, n);
      t += n;
      if (k < 5) begin
        n_check++;
        if (n !== exp_sp[k])
          $display("FAIL frac_sp k=%0d got=%0d exp=%0d", k, n, exp_sp[k]);
        else n_pass++;
      end
    end
    n_check++;
    if (t !== 89) $display("FAIL frac_span got=%0d exp=89", t);
    else n_pass++;
  endtask

  task automatic test_reload;
    int n;
    restart(3, 0);
    wait_tick(20, n);
    @(negedge clock);
    load     = 1'b1;
    dvsr_int = 11'd7;
    @(negedge clock);
    load = 1'b0;
    n_check++;
    if (pending !== 1'b1) $display("FAIL reload_pend got=%b exp=1", pending);
    else n_pass++;
    wait_tick(20, n);
    n_check++;
    if (n !== 2) $display("FAIL reload_old got=%0d exp=2", n);
    else n_pass++;
    n_check++;
    if (pending !== 1'b0) $display("FAIL reload_clr got=%b exp=0", pending);
    else n_pass++;
    wait_tick(20, n);
    n_check++;
    if (n !== 8) $display("FAIL reload_new got=%0d exp=8", n);
    else n_pass++;
  endtask

  task automatic test_enable;
    int n;
    int ticks;
    logic [3:0] idx0;
    restart(3, 0);
    wait_tick(20, n);
    @(negedge clock);
    idx0   = sample_idx;
    enable = 1'b0;
    ticks  = 0;
    repeat (10) begin
      @(negedge clock);
      if (sample_tick) ticks++;
    end
    n_check++;
    if (ticks !== 0) $display("FAIL gap_ticks got=%0d exp=0", ticks);
    else n_pass++;
    n_check++;
    if (sample_idx !== idx0)
      $display("FAIL gap_idx got=%0d exp=%0d", sample_idx, idx0);
    else n_pass++;
    enable = 1'b1;
    wait_tick(20, n);
    n_check++;
    if (n + 11 !== 14) $display("FAIL gap_span got=%0d exp=14", n + 11);
    else n_pass++;
  endtask

  task automatic test_clear_load;
    int n;
    restart(3, 0);
    wait_tick(20, n);
    load     = 1'b1;
    dvsr_int = 11'd9;
    @(negedge clock);
    load = 1'b0;
    restart(1, 0);
    n_check++;
    if ({pending, sample_idx, sample_tick} !== 6'd0)
      $display("FAIL clr_state got=%b exp=0",
               {pending, sample_idx, sample_tick});
    else n_pass++;
    wait_tick(20, n);
    n_check++;
    if (n !== 2) $display("FAIL clr_first got=%0d exp=2", n);
    else n_pass++;
    n_check++;
    if (sample_idx !== 4'd1)
      $display("FAIL clr_idx got=%0d exp=1", sample_idx);
    else n_pass++;
    wait_tick(20, n);
    n_check++;
    if (n !== 2) $display("FAIL clr_second got=%0d exp=2", n);
    else n_pass++;
  endtask

  task automatic test_zero_div;
    int ticks;
    restart(0, 0);
    ticks = 0;
    repeat (5) begin
      @(negedge clock);
      if (sample_tick) ticks++;
    end
    n_check++;
    if (ticks !== 5) $display("FAIL zero_div got=%0d exp=5", ticks);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    restart(3, 0);
    wait_tick(20, n);
    load     = 1'b1;
    dvsr_int = 11'd5;
    @(negedge clock);
    load  = 1'b0;
    reset = 1'b0;
    #1;
    n_check++;
    if ({sample_tick, bit_tick, pending, sample_idx} !== 7'd0)
      $display("FAIL mid_reset got=%b exp=0",
               {sample_tick, bit_tick, pending, sample_idx});
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    wait_tick(400, n);
    n_check++;
    if (n !== 326) $display("FAIL mid_latency got=%0d exp=326", n);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_bit_tick;
    test_frac;
    test_reload;
    test_enable;
    test_clear_load;
    test_zero_div;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
